alu_op_sequencer: RTL and testbench

Control-side counterpart of the SAP-2 ALU: accepts one opcode per handshake from the instruction path, issues exactly one registered ALU control strobe with operand source select and accumulator load, and consumes the ALU zero/sign flags to resolve conditional jumps. Immediate logic ops (ANI/ORI/XRI) fetch their operand through a read/ready handshake to memory before executing. Sits between the instruction register/fetch unit and the ALU, accumulator and TMP registers.

---
 rtl/sap2_alu_pkg.sv | 89 ++++++++
 rtl/alu_op_sequencer_if.sv | 42 ++++
 rtl/alu_opcode_decoder.sv | 97 +++++++++
 rtl/alu_op_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sap2_alu_pkg.sv
// Shared definitions for the SAP-2 ALU control path.
// Holds opcode values, FSM/op-class encodings and the decoder result record.
package sap2_alu_pkg;

    localparam logic [7:0] OP_ADD_B = 8'h80;
    localparam logic [7:0] OP_ADD_C = 8'h81;
    localparam logic [7:0] OP_SUB_B = 8'h90;
    localparam logic [7:0] OP_SUB_C = 8'h91;
    localparam logic [7:0] OP_ANA_B = 8'hA0;
    localparam logic [7:0] OP_ANA_C = 8'hA1;
    localparam logic [7:0] OP_XRA_B = 8'hA8;
    localparam logic [7:0] OP_XRA_C = 8'hA9;
    localparam logic [7:0] OP_ORA_B = 8'hB0;
    localparam logic [7:0] OP_ORA_C = 8'hB1;
    localparam logic [7:0] OP_INR_A = 8'h3C;
    localparam logic [7:0] OP_DCR_A = 8'h3D;
    localparam logic [7:0] OP_RAL   = 8'h17;
    localparam logic [7:0] OP_RAR   = 8'h1F;
    localparam logic [7:0] OP_ANI   = 8'hE6;
    localparam logic [7:0] OP_XRI   = 8'hEE;
    localparam logic [7:0] OP_ORI   = 8'hF6;
    localparam logic [7:0] OP_JNZ   = 8'hC2;
    localparam logic [7:0] OP_JZ    = 8'hCA;
    localparam logic [7:0] OP_JM    = 8'hFA;

    localparam logic [1:0] SRC_B      = 2'd0;
    localparam logic [1:0] SRC_C      = 2'd1;
    localparam logic [1:0] SRC_TMP    = 2'd2;
    localparam logic [1:0] SRC_UNUSED = 2'd3;

    localparam int NUM_STROBES = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_FETCH,
        ST_EXEC,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_ARITH,
        CLS_LOGIC,
        CLS_UNARY,
        CLS_IMM,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_t;

    // Values double as bit positions in the strobe vector.
    typedef enum logic [3:0] {
        STB_ADD  = 4'd0,
        STB_SUB  = 4'd1,
        STB_AND  = 4'd2,
        STB_OR   = 4'd3,
        STB_XOR  = 4'd4,
        STB_INC  = 4'd5,
        STB_DEC  = 4'd6,
        STB_RAL  = 4'd7,
        STB_RAR  = 4'd8,
        STB_NONE = 4'd9
    } strobe_idx_t;

    typedef enum logic [1:0] {
        JC_NONE,
        JC_Z,
        JC_NZ,
        JC_M
    } jump_cond_t;

    typedef struct packed {
        op_class_t   op_class;
        strobe_idx_t strobe;
        logic [1:0]  src_sel;
        jump_cond_t  jump_cond;
    } decode_t;

    function automatic logic jump_taken(input jump_cond_t cond, input logic zero, input logic sign);
        logic taken;
        case (cond)
            JC_Z:    taken = zero;
            JC_NZ:   taken = !zero;
            JC_M:    taken = sign;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction-path handshake, memory fetch handshake and ALU control bundle.
// The master side drives opcodes/flags; the slave side is the sequencer.
interface alu_op_sequencer_if #(
    parameter int OPW = 8
);
    logic           iStart;
    logic [OPW-1:0] iOpcode;
    logic           iZeroFlag;
    logic           iSignFlag;
    logic           iMemReady;
    logic           oMemRead;
    logic           oAdd;
    logic           oSub;
    logic           oAND;
    logic           oOR;
    logic           oXOR;
    logic           oInc;
    logic           oDec;
    logic           oRotateLeft;
    logic           oRotateRight;
    logic [1:0]     oSrcSel;
    logic           oLoadAcc;
    logic           oBusy;
    logic           oDone;
    logic           oJumpTaken;
    logic           oIllegal;
    logic           oError;

    modport master (
        output iStart, iOpcode, iZeroFlag, iSignFlag, iMemReady,
        input  oMemRead, oAdd, oSub, oAND, oOR, oXOR, oInc, oDec,
               oRotateLeft, oRotateRight, oSrcSel, oLoadAcc,
               oBusy, oDone, oJumpTaken, oIllegal, oError
    );

    modport slave (
        input  iStart, iOpcode, iZeroFlag, iSignFlag, iMemReady,
        output oMemRead, oAdd, oSub, oAND, oOR, oXOR, oInc, oDec,
               oRotateLeft, oRotateRight, oSrcSel, oLoadAcc,
               oBusy, oDone, oJumpTaken, oIllegal, oError
    );
endinterface

// File: rtl/alu_opcode_decoder.sv
// Combinational opcode classifier: op class, ALU strobe, B-operand source
// and jump condition for one SAP-2 opcode.
module alu_opcode_decoder
    import sap2_alu_pkg::*;
#(
    parameter int OPW = 8
) (
    input  logic [OPW-1:0] i_opcode,
    output decode_t        o_decode
);

    logic [1:0] w_reg_src;

    // Register forms encode B/C in bit 0.
    assign w_reg_src = i_opcode[0] ? SRC_C : SRC_B;

    always_comb begin
        o_decode.op_class  = CLS_ILLEGAL;
        o_decode.strobe    = STB_NONE;
        o_decode.src_sel   = SRC_B;
        o_decode.jump_cond = JC_NONE;
        case (i_opcode)
            OPW'(OP_ADD_B), OPW'(OP_ADD_C): begin
                o_decode.op_class = CLS_ARITH;
                o_decode.strobe   = STB_ADD;
                o_decode.src_sel  = w_reg_src;
            end
            OPW'(OP_SUB_B), OPW'(OP_SUB_C): begin
                o_decode.op_class = CLS_ARITH;
                o_decode.strobe   = STB_SUB;
                o_decode.src_sel  = w_reg_src;
            end
            OPW'(OP_ANA_B), OPW'(OP_ANA_C): begin
                o_decode.op_class = CLS_LOGIC;
                o_decode.strobe   = STB_AND;
                o_decode.src_sel  = w_reg_src;
            end
            OPW'(OP_XRA_B), OPW'(OP_XRA_C): begin
                o_decode.op_class = CLS_LOGIC;
                o_decode.strobe   = STB_XOR;
                o_decode.src_sel  = w_reg_src;
            end
            OPW'(OP_ORA_B), OPW'(OP_ORA_C): begin
                o_decode.op_class = CLS_LOGIC;
                o_decode.strobe   = STB_OR;
                o_decode.src_sel  = w_reg_src;
            end
            OPW'(OP_INR_A): begin
                o_decode.op_class = CLS_UNARY;
                o_decode.strobe   = STB_INC;
            end
            OPW'(OP_DCR_A): begin
                o_decode.op_class = CLS_UNARY;
                o_decode.strobe   = STB_DEC;
            end
            OPW'(OP_RAL): begin
                o_decode.op_class = CLS_UNARY;
                o_decode.strobe   = STB_RAL;
            end
            OPW'(OP_RAR): begin
                o_decode.op_class = CLS_UNARY;
                o_decode.strobe   = STB_RAR;
            end
            OPW'(OP_ANI): begin
                o_decode.op_class = CLS_IMM;
                o_decode.strobe   = STB_AND;
                o_decode.src_sel  = SRC_TMP;
            end
            OPW'(OP_XRI): begin
                o_decode.op_class = CLS_IMM;
                o_decode.strobe   = STB_XOR;
                o_decode.src_sel  = SRC_TMP;
            end
            OPW'(OP_ORI): begin
                o_decode.op_class = CLS_IMM;
                o_decode.strobe   = STB_OR;
                o_decode.src_sel  = SRC_TMP;
            end
            OPW'(OP_JNZ): begin
                o_decode.op_class  = CLS_JUMP;
                o_decode.jump_cond = JC_NZ;
            end
            OPW'(OP_JZ): begin
                o_decode.op_class  = CLS_JUMP;
                o_decode.jump_cond = JC_Z;
            end
            OPW'(OP_JM): begin
                o_decode.op_class  = CLS_JUMP;
                o_decode.jump_cond = JC_M;
            end
            default: begin
                o_decode.op_class = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// SAP-2 ALU control sequencer: one opcode per handshake, one registered ALU
// strobe per op, immediate operand fetch with timeout, conditional jump resolve.
module alu_op_sequencer
    import sap2_alu_pkg::*;
#(
    parameter int OPW     = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               iClock,
    input  logic               iReset,
    alu_op_sequencer_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [OPW-1:0]         r_opcode;
    logic [OPW-1:0]         w_opcode_next;
    logic [CW-1:0]          r_fetch_cnt;
    logic [CW-1:0]          w_fetch_cnt_next;
    logic [CW-1:0]          w_fetch_cnt_inc;

    logic [NUM_STROBES-1:0] r_strobe;
    logic [NUM_STROBES-1:0] w_strobe_next;
    logic [NUM_STROBES-1:0] w_strobe_onehot;
    logic [1:0]             r_src_sel;
    logic [1:0]             w_src_sel_next;
    logic                   r_load_acc;
    logic                   r_mem_read;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_jump_taken;
    logic                   w_jump_taken_next;
    logic                   r_illegal;
    logic                   w_illegal_next;
    logic                   r_error;
    logic                   w_error_next;

    decode_t                w_decode;

    alu_opcode_decoder #(
        .OPW (OPW)
    ) u_decoder (
        .i_opcode (r_opcode),
        .o_decode (w_decode)
    );

    generate
        for (genvar gi = 0; gi < NUM_STROBES; gi++) begin : g_strobe
            assign w_strobe_onehot[gi] = (w_decode.strobe == strobe_idx_t'(gi));
        end
    endgenerate

    assign w_fetch_cnt_inc = r_fetch_cnt + CW'(1);

    always_comb begin
        w_state_next      = r_state;
        w_opcode_next     = r_opcode;
        w_fetch_cnt_next  = r_fetch_cnt;
        w_jump_taken_next = 1'b0;
        w_illegal_next    = 1'b0;
        w_error_next      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.iStart) begin
                    w_opcode_next = bus.iOpcode;
                    w_state_next  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_fetch_cnt_next = '0;
                case (w_decode.op_class)
                    CLS_ILLEGAL: begin
                        w_illegal_next = 1'b1;
                        w_state_next   = ST_DONE;
                    end
                    CLS_JUMP: begin
                        w_jump_taken_next = jump_taken(w_decode.jump_cond, bus.iZeroFlag, bus.iSignFlag);
                        w_state_next      = ST_DONE;
                    end
                    CLS_IMM: w_state_next = ST_FETCH;
                    default: w_state_next = ST_EXEC;
                endcase
            end
            ST_FETCH: begin
                // Ready takes priority over a timeout landing in the same cycle.
                if (bus.iMemReady) begin
                    w_fetch_cnt_next = '0;
                    w_state_next     = ST_EXEC;
                end else if (w_fetch_cnt_inc == CW'(TIMEOUT)) begin
                    w_fetch_cnt_next = '0;
                    w_error_next     = 1'b1;
                    w_state_next     = ST_DONE;
                end else begin
                    w_fetch_cnt_next = w_fetch_cnt_inc;
                end
            end
            ST_EXEC: w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        w_strobe_next  = '0;
        w_src_sel_next = SRC_B;
        if (w_state_next == ST_EXEC) begin
            w_strobe_next  = w_strobe_onehot;
            w_src_sel_next = w_decode.src_sel;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_state      <= ST_IDLE;
            r_opcode     <= '0;
            r_fetch_cnt  <= '0;
            r_strobe     <= '0;
            r_src_sel    <= SRC_B;
            r_load_acc   <= 1'b0;
            r_mem_read   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_jump_taken <= 1'b0;
            r_illegal    <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_opcode     <= w_opcode_next;
            r_fetch_cnt  <= w_fetch_cnt_next;
            r_strobe     <= w_strobe_next;
            r_src_sel    <= w_src_sel_next;
            r_load_acc   <= (w_state_next == ST_EXEC);
            r_mem_read   <= (w_state_next == ST_FETCH);
            r_busy       <= (w_state_next != ST_IDLE);
            r_done       <= (w_state_next == ST_DONE);
            r_jump_taken <= w_jump_taken_next;
            r_illegal    <= w_illegal_next;
            r_error      <= w_error_next;
        end
    end

    assign bus.oAdd         = r_strobe[STB_ADD];
    assign bus.oSub         = r_strobe[STB_SUB];
    assign bus.oAND         = r_strobe[STB_AND];
    assign bus.oOR          = r_strobe[STB_OR];
    assign bus.oXOR         = r_strobe[STB_XOR];
    assign bus.oInc         = r_strobe[STB_INC];
    assign bus.oDec         = r_strobe[STB_DEC];
    assign bus.oRotateLeft  = r_strobe[STB_RAL];
    assign bus.oRotateRight = r_strobe[STB_RAR];
    assign bus.oSrcSel      = r_src_sel;
    assign bus.oLoadAcc     = r_load_acc;
    assign bus.oMemRead     = r_mem_read;
    assign bus.oBusy        = r_busy;
    assign bus.oDone        = r_done;
    assign bus.oJumpTaken   = r_jump_taken;
    assign bus.oIllegal     = r_illegal;
    assign bus.oError       = r_error;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: opcode vector table applied back-to-back,
// plus reset-during-EXEC and busy-time iStart sequences.
module tb_alu_op_sequencer;

    logic iClock;
    logic iReset;
    int   checks;
    int   errors;

    alu_op_sequencer_if #(.OPW(8)) bus ();

    alu_op_sequencer #(
        .OPW     (8),
        .TIMEOUT (15)
    ) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    typedef struct {
        logic [7:0] op;
        logic       z;
        logic       s;
        int         ready_at;   // FETCH cycle (1-based) with iMemReady high, 0 = never
        logic [8:0] exp_stb;    // {RAR,RAL,DEC,INC,XOR,OR,AND,SUB,ADD}
        logic [1:0] exp_src;
        int         exp_done;   // cycle of oDone, iStart cycle = 0
        logic       exp_ill;
        logic       exp_jmp;
        logic       exp_err;
        int         exp_mr;     // cycles with oMemRead high
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [7:0] op, input logic z, input logic s, input int rdy,
                                input logic [8:0] stb, input logic [1:0] src, input int dn,
                                input logic ill, input logic jmp, input logic err, input int mr);
        vec_t v;
        v.op = op; v.z = z; v.s = s; v.ready_at = rdy; v.exp_stb = stb; v.exp_src = src;
        v.exp_done = dn; v.exp_ill = ill; v.exp_jmp = jmp; v.exp_err = err; v.exp_mr = mr;
        return v;
    endfunction

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    function automatic logic [8:0] strobes();
        return {bus.oRotateRight, bus.oRotateLeft, bus.oDec, bus.oInc, bus.oXOR,
                bus.oOR, bus.oAND, bus.oSub, bus.oAdd};
    endfunction

    // Issues one opcode in the current (IDLE) cycle and watches it to oDone,
    // returning in the IDLE cycle that follows DONE.
    task automatic run_op(input vec_t v);
        int         cyc;
        int         done_cyc;
        int         fetch_n;
        int         stb_cnt;
        int         load_cnt;
        int         multi;
        logic [8:0] stb_or;
        logic [1:0] src_seen;
        logic       busy1;
        logic       ill, jmp, err;
        string      tag;
        tag = $sformatf("op%02h", v.op);
        done_cyc = -1; fetch_n = 0; stb_cnt = 0; load_cnt = 0; multi = 0;
        stb_or = '0; src_seen = 2'd3; busy1 = 1'b0; ill = 1'b0; jmp = 1'b0; err = 1'b0;
        bus.iStart    = 1'b1;
        bus.iOpcode   = v.op;
        bus.iZeroFlag = v.z;
        bus.iSignFlag = v.s;
        bus.iMemReady = 1'b0;
        step();
        bus.iStart = 1'b0;
        cyc = 1;
        while (cyc <= 40 && done_cyc < 0) begin
            if (cyc == 1) busy1 = bus.oBusy;
            stb_cnt += $countones(strobes());
            if ($countones(strobes()) > 1) multi = 1;
            stb_or |= strobes();
            if (bus.oLoadAcc) begin
                load_cnt++;
                src_seen = bus.oSrcSel;
            end
            if (bus.oDone) begin
                done_cyc = cyc;
                ill = bus.oIllegal;
                jmp = bus.oJumpTaken;
                err = bus.oError;
            end
            if (bus.oMemRead) begin
                fetch_n++;
                bus.iMemReady = (v.ready_at != 0) && (fetch_n == v.ready_at);
            end else begin
                bus.iMemReady = 1'b0;
            end
            step();
            cyc++;
        end
        bus.iMemReady = 1'b0;
        chk({tag, " done_cycle"}, done_cyc, v.exp_done);
        chk({tag, " busy_c1"}, int'(busy1), 1);
        chk({tag, " strobe_set"}, int'(stb_or), int'(v.exp_stb));
        chk({tag, " strobe_count"}, stb_cnt, $countones(v.exp_stb));
        chk({tag, " strobe_overlap"}, multi, 0);
        chk({tag, " load_acc_count"}, load_cnt, $countones(v.exp_stb));
        if (v.exp_stb != 0) chk({tag, " src_sel"}, int'(src_seen), int'(v.exp_src));
        chk({tag, " mem_read_cycles"}, fetch_n, v.exp_mr);
        chk({tag, " illegal"}, int'(ill), int'(v.exp_ill));
        chk({tag, " jump_taken"}, int'(jmp), int'(v.exp_jmp));
        chk({tag, " error"}, int'(err), int'(v.exp_err));
        chk({tag, " idle_after_done"}, int'(bus.oBusy), 0);
        $display("op %02h z=%0d s=%0d rdy=%0d -> done@%0d stb=%03h src=%0d ill=%0d jmp=%0d err=%0d mr=%0d",
                 v.op, v.z, v.s, v.ready_at, done_cyc, stb_or, src_seen, ill, jmp, err, fetch_n);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " strobes"}, int'(strobes()), 0);
        chk({name, " load_acc"}, int'(bus.oLoadAcc), 0);
        chk({name, " busy"}, int'(bus.oBusy), 0);
        chk({name, " done"}, int'(bus.oDone), 0);
        chk({name, " mem_read"}, int'(bus.oMemRead), 0);
        chk({name, " status"}, int'({bus.oIllegal, bus.oJumpTaken, bus.oError, bus.oSrcSel}), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        iReset = 1'b0;
        bus.iStart = 1'b0; bus.iOpcode = '0; bus.iZeroFlag = 1'b0;
        bus.iSignFlag = 1'b0; bus.iMemReady = 1'b0;

        vecs[0]  = mk(8'h80, 0, 0, 0, 9'h001, 2'd0, 3, 0, 0, 0, 0);
        vecs[1]  = mk(8'h81, 0, 0, 0, 9'h001, 2'd1, 3, 0, 0, 0, 0);
        vecs[2]  = mk(8'h90, 0, 0, 0, 9'h002, 2'd0, 3, 0, 0, 0, 0);
        vecs[3]  = mk(8'h91, 0, 0, 0, 9'h002, 2'd1, 3, 0, 0, 0, 0);
        vecs[4]  = mk(8'hA0, 0, 0, 0, 9'h004, 2'd0, 3, 0, 0, 0, 0);
        vecs[5]  = mk(8'hA1, 0, 0, 0, 9'h004, 2'd1, 3, 0, 0, 0, 0);
        vecs[6]  = mk(8'hA8, 0, 0, 0, 9'h010, 2'd0, 3, 0, 0, 0, 0);
        vecs[7]  = mk(8'hA9, 0, 0, 0, 9'h010, 2'd1, 3, 0, 0, 0, 0);
        vecs[8]  = mk(8'hB0, 0, 0, 0, 9'h008, 2'd0, 3, 0, 0, 0, 0);
        vecs[9]  = mk(8'hB1, 0, 0, 0, 9'h008, 2'd1, 3, 0, 0, 0, 0);
        vecs[10] = mk(8'h3C, 0, 0, 0, 9'h020, 2'd0, 3, 0, 0, 0, 0);
        vecs[11] = mk(8'h3D, 0, 0, 0, 9'h040, 2'd0, 3, 0, 0, 0, 0);
        vecs[12] = mk(8'h17, 0, 0, 0, 9'h080, 2'd0, 3, 0, 0, 0, 0);
        vecs[13] = mk(8'h1F, 0, 0, 0, 9'h100, 2'd0, 3, 0, 0, 0, 0);
        vecs[14] = mk(8'hE6, 0, 0, 1, 9'h004, 2'd2, 4, 0, 0, 0, 1);
        vecs[15] = mk(8'hEE, 0, 0, 2, 9'h010, 2'd2, 5, 0, 0, 0, 2);
        vecs[16] = mk(8'hF6, 0, 0, 3, 9'h008, 2'd2, 6, 0, 0, 0, 3);
        vecs[17] = mk(8'hC2, 0, 0, 0, 9'h000, 2'd0, 2, 0, 1, 0, 0);
        vecs[18] = mk(8'hCA, 1, 0, 0, 9'h000, 2'd0, 2, 0, 1, 0, 0);
        vecs[19] = mk(8'hFA, 0, 1, 0, 9'h000, 2'd0, 2, 0, 1, 0, 0);
        vecs[20] = mk(8'hC2, 1, 0, 0, 9'h000, 2'd0, 2, 0, 0, 0, 0);
        vecs[21] = mk(8'hCA, 0, 1, 0, 9'h000, 2'd0, 2, 0, 0, 0, 0);
        vecs[22] = mk(8'hFA, 1, 0, 0, 9'h000, 2'd0, 2, 0, 0, 0, 0);
        vecs[23] = mk(8'h00, 0, 0, 0, 9'h000, 2'd0, 2, 1, 0, 0, 0);
        vecs[24] = mk(8'hFF, 0, 0, 0, 9'h000, 2'd0, 2, 1, 0, 0, 0);
        vecs[25] = mk(8'hE6, 0, 0, 0, 9'h000, 2'd0, 17, 0, 0, 1, 15);
        vecs[26] = mk(8'hE6, 0, 0, 15, 9'h004, 2'd2, 18, 0, 0, 0, 15);

        step();
        step();
        chk_quiet("reset_held");
        iReset = 1'b1;
        step();
        chk_quiet("after_reset");

        for (int i = 0; i < NV; i++) run_op(vecs[i]);

        // Reset asserted in the middle of an ADD B EXEC cycle.
        bus.iStart = 1'b1; bus.iOpcode = 8'h80;
        step();
        bus.iStart = 1'b0;
        step();
        chk("rst_exec add_before", int'(bus.oAdd), 1);
        chk("rst_exec load_before", int'(bus.oLoadAcc), 1);
        #2 iReset = 1'b0;
        #1;
        chk_quiet("rst_exec async");
        $display("reset mid-EXEC: strobes=%03h load=%0d busy=%0d", strobes(), bus.oLoadAcc, bus.oBusy);
        step();
        iReset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet($sformatf("rst_exec post_c%0d", i));
        end

        // iStart held during DECODE of an illegal op must not launch a second op.
        bus.iStart = 1'b1; bus.iOpcode = 8'h00;
        step();
        bus.iOpcode = 8'h80;
        step();
        bus.iStart = 1'b0;
        chk("busy_ignore done", int'(bus.oDone), 1);
        chk("busy_ignore illegal", int'(bus.oIllegal), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet($sformatf("busy_ignore idle_c%0d", i));
        end
        $display("iStart during busy: ignored check done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
